// File: rtl/led_seq_player.sv
// led_seq_player: one-hot LED sequencer driven by play/stop buttons.
// Wrap or ping-pong stepping, manual or timed advance, pause state.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   play      play button level, synchronous to clk
//   stop      stop button level, synchronous to clk
//   auto_en   1 = timed advance every STEP_DIV cycles, 0 = per play press
//   pingpong  0 = wrap stepping, 1 = bounce stepping
//   leds      one-hot LED drive, inverted when ACTIVE_LOW = 1
//   pos       current lit index (0 = idle position)
//   playing   high while in RUN
module led_seq_player #(
    parameter int N_LEDS     = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int STEP_DIV   = 4,
    localparam int PW = (N_LEDS > 2) ? $clog2(N_LEDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              stop,
    input  logic              auto_en,
    input  logic              pingpong,
    output logic [N_LEDS-1:0] leds,
    output logic [PW-1:0]     pos,
    output logic              playing
);

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW-1:0] P_TWO  = PW'(2);
    localparam logic [PW-1:0] P_LAST = PW'(N_LEDS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(STEP_DIV - 1);

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t        state;
    logic          dir;
    logic [DW-1:0] div_cnt;
    logic          play_q;
    logic          stop_q;
    logic          play_p;
    logic          stop_p;
    logic [PW-1:0] nxt_pos;
    logic          nxt_dir;

    assign play_p = play & ~play_q;
    assign stop_p = stop & ~stop_q;

    // Next position and direction for one advance. Wrap mode always
    // steps upward, even if a previous ping-pong left dir = down.
    always_comb begin
        nxt_pos = pos;
        nxt_dir = UP;
        if (!pingpong) begin
            nxt_pos = (pos == P_LAST) ? P_ONE : pos + P_ONE;
        end else if (N_LEDS == 2) begin
            nxt_pos = P_ONE;
        end else if (dir == UP) begin
            if (pos == P_LAST) begin
                nxt_pos = pos - P_ONE;
                nxt_dir = DOWN;
            end else begin
                nxt_pos = pos + P_ONE;
            end
        end else begin
            if (pos == P_ONE) begin
                nxt_pos = P_TWO;
            end else begin
                nxt_pos = pos - P_ONE;
                nxt_dir = DOWN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pos     <= '0;
            dir     <= UP;
            div_cnt <= '0;
            playing <= 1'b0;
            // Reset high so a button held through reset is not a press.
            play_q  <= 1'b1;
            stop_q  <= 1'b1;
        end else begin
            play_q <= play;
            stop_q <= stop;
            if (stop_p) begin
                state   <= IDLE;
                pos     <= '0;
                dir     <= UP;
                div_cnt <= '0;
                playing <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (play_p) begin
                            state   <= RUN;
                            pos     <= P_ONE;
                            dir     <= UP;
                            div_cnt <= '0;
                            playing <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (auto_en) begin
                            // The divider still ticks on the edge that
                            // pauses, so resume continues mid-period.
                            if (div_cnt == D_LAST) begin
                                pos     <= nxt_pos;
                                dir     <= nxt_dir;
                                div_cnt <= '0;
                            end else begin
                                div_cnt <= div_cnt + DW'(1);
                            end
                            if (play_p) begin
                                state   <= PAUSE;
                                playing <= 1'b0;
                            end
                        end else begin
                            div_cnt <= '0;
                            if (play_p) begin
                                pos <= nxt_pos;
                                dir <= nxt_dir;
                            end
                        end
                    end
                    PAUSE: begin
                        if (play_p) begin
                            state   <= RUN;
                            playing <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        pos     <= '0;
                        dir     <= UP;
                        div_cnt <= '0;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            leds[i] = (pos == PW'(i)) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: doc/led_seq_player.md
Name: led_seq_player

Overview:
Parametrised LED sequencer driven by play/stop push-buttons. It generalises the fixed 4-LED, two-step player to N LEDs, with wrap or ping-pong stepping, manual or timed auto-advance, and a pause state. It sits between the debounced button inputs and the board LED pins. Exactly one LED is lit at any time.

Parameters:
N_LEDS, 4, number of LEDs; legal values >= 2.
ACTIVE_LOW, 1, 1 = lit LED driven 0 and others 1; 0 = lit LED driven 1.
STEP_DIV, 4, clock cycles per automatic step; legal values >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
play  input  1  play button, level, synchronous to clk.
stop  input  1  stop button, level, synchronous to clk.
auto_en  input  1  1 = timed auto-advance; 0 = each play press advances.
pingpong  input  1  0 = wrap stepping; 1 = bounce stepping.
leds  output  N_LEDS  one-hot LED drive, polarity per ACTIVE_LOW.
pos  output  PW  current lit index, PW = max(1, clog2(N_LEDS)).
playing  output  1  high in RUN only.

Behaviour:
- Reset, asynchronous, rst_n low: state = IDLE, pos = 0, dir = up, div_cnt = 0, playing = 0.
- Reset value of leds: bit 0 lit. With ACTIVE_LOW=1 and N_LEDS=4 this is 4'b1110.
- Reset value of play_q/stop_q is 1. A button held through reset release does not register a press.
- Press detection: play_p = play & ~play_q; stop_p = stop & ~stop_q. play_q/stop_q are registered every cycle.
- A held button produces exactly one press.
- All outputs are registered. They update on the same clk edge that first samples the button high, so latency is 1 edge.
- Index 0 is the idle position. RUN and PAUSE use indices 1..N_LEDS-1 only.
- States: IDLE, RUN, PAUSE.
- IDLE: pos = 0.
  - play_p -> RUN, pos = 1, dir = up, div_cnt = 0.
- RUN, manual (auto_en=0): play_p -> advance pos. div_cnt is held at 0.
- RUN, auto (auto_en=1):
  - div_cnt counts 0..STEP_DIV-1.
  - At STEP_DIV-1: advance pos and div_cnt = 0.
  - play_p -> PAUSE.
  - With STEP_DIV=1, pos advances every cycle.
- PAUSE: pos and div_cnt are frozen.
  - play_p -> RUN with no advance. div_cnt resumes from its held value.
- stop_p from any state -> IDLE, pos = 0, div_cnt = 0, dir = up.
- stop_p and play_p in the same cycle: stop wins.
- Advance, wrap (pingpong=0): pos+1; N_LEDS-1 -> 1.
- Advance, ping-pong (pingpong=1):
  - dir up: pos+1; at N_LEDS-1, dir flips to down and pos becomes N_LEDS-2.
  - dir down: pos-1; at 1, dir flips to up and pos becomes 2.
  - With N_LEDS=2, pos stays 1.
  - With N_LEDS=3, pos alternates 1,2,1,2.
- Changing pingpong mid-run: applies from the next advance.
  - If dir = down when wrap is selected, stepping continues upward from the current pos.
- Changing auto_en mid-run: applies next cycle. The state is unchanged.
- leds is a pure function of registered pos: one-hot of pos, inverted when ACTIVE_LOW=1.
- playing = (state == RUN).

Test Plan:
1. Reset with N_LEDS=4, ACTIVE_LOW=1 -> leds=4'b1110, pos=0, playing=0. Assert rst_n mid-RUN at pos=3 -> immediately leds=4'b1110, state IDLE.
2. Manual wrap: 5 play presses -> pos 1,2,3,1,2 and leds 1101,1011,0111,1101,1011. Then stop -> leds=1110, playing=0.
3. Manual ping-pong, N_LEDS=5: 9 presses -> pos 1,2,3,4,3,2,1,2,3.
4. Auto, STEP_DIV=3, wrap, N_LEDS=4, press at edge 0:
   - pos=1 at edge 0, 2 at edge 3, 3 at edge 6, 1 at edge 9.
   - Press play at edge 10 (div_cnt=1) -> PAUSE, pos stays 1 for 20 cycles.
   - Press play again -> RUN, next advance after 2 more cycles.
5. Edge cases:
   - play and stop rising in the same cycle during RUN -> IDLE, pos 0.
   - play held high 50 cycles in manual RUN -> exactly one advance.
   - play high across rst_n release -> stays IDLE.
6. N_LEDS=8, ACTIVE_LOW=0, manual wrap: press 7 times -> pos 1..7 then 1. At pos=7, leds=8'h80. In IDLE, leds=8'h01.
